mtsp_gscs_bank: RTL and testbench



---
 rtl/mtsp_gscs_bank.sv | 99 +++++++++
 tb/tb_mtsp_gscs_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_gscs_bank.sv
// rtl/mtsp_gscs_bank.sv - global scratch-counter bank, four 16-bit fetch-and-op lanes
// Lane l (0=X..3=W) lives at bit offset 16*(3-l); op nibbles at 4*(3-l) within a core's 16-bit field.
module mtsp_gscs_bank #(
    parameter int unsigned CORE_COUNT = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CORE_COUNT-1:0]      REQ_nEN,
    input  logic [16*CORE_COUNT-1:0]   REQ_OP,
    input  logic [64*CORE_COUNT-1:0]   REQ_DATA,
    output logic [64*CORE_COUNT-1:0]   GSCs_DATA,
    input  logic                       HOST_nWE,
    input  logic [63:0]                HOST_DATA,
    output logic [63:0]                COUNTERS,
    output logic [3:0]                 OVF
);

    logic [63:0]              counter_q, counter_d;
    logic [3:0]               ovf_q, ovf_d;
    logic [64*CORE_COUNT-1:0] gdata_q, gdata_d;

    // Returns {wrap_flag, result}; wrap_flag is carry for add and borrow for sub.
    function automatic logic [16:0] lane_op(input logic [15:0] c, input logic [15:0] d,
                                            input logic [2:0] op);
        logic [16:0] r;
        r = {1'b0, c};
        case (op)
            3'd0: r = {1'b0, c};
            3'd1: r = {1'b0, c} + {1'b0, d};
            3'd2: r = {1'b0, c} - {1'b0, d};
            3'd3: r = {1'b0, d};
            3'd4: r = {1'b0, (d < c) ? d : c};
            3'd5: r = {1'b0, (d > c) ? d : c};
            3'd6: r = {1'b0, d};
            3'd7: r = 17'd0;
            default: r = {1'b0, c};
        endcase
        return r;
    endfunction

    always_comb begin
        logic [15:0] chain;
        logic [16:0] res;
        logic [3:0]  op;
        logic [15:0] opnd;
        logic [63:0] chained;
        logic [3:0]  ovf_set;
        chain   = '0;
        res     = '0;
        op      = '0;
        opnd    = '0;
        chained = '0;
        ovf_set = '0;
        gdata_d = gdata_q;
        for (int l = 0; l < 4; l++) begin
            chain = counter_q[16*(3-l) +: 16];
            for (int c = 0; c < int'(CORE_COUNT); c++) begin
                op   = REQ_OP[16*c + 4*(3-l) +: 4];
                opnd = REQ_DATA[64*c + 16*(3-l) +: 16];
                if (!REQ_nEN[c]) begin
                    gdata_d[64*c + 16*(3-l) +: 16] = chain;
                    if (op[3]) begin
                        res   = lane_op(chain, opnd, op[2:0]);
                        chain = res[15:0];
                        if (op[2:1] == 2'b00 || op[2:0] == 3'd2) begin
                            ovf_set[3-l] = ovf_set[3-l] | res[16];
                        end
                    end
                end
            end
            chained[16*(3-l) +: 16] = chain;
        end
        // Host load wins over the chain but returned values still come from the chain.
        if (!HOST_nWE) begin
            counter_d = HOST_DATA;
            ovf_d     = '0;
        end else begin
            counter_d = chained;
            ovf_d     = ovf_q | ovf_set;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            counter_q <= '0;
            ovf_q     <= '0;
            gdata_q   <= '0;
        end else begin
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
            gdata_q   <= gdata_d;
        end
    end

    assign COUNTERS  = counter_q;
    assign OVF       = ovf_q;
    assign GSCs_DATA = gdata_q;

endmodule

// File: tb/tb_mtsp_gscs_bank.sv
// tb/tb_mtsp_gscs_bank.sv - directed and randomized checks of mtsp_gscs_bank against a lane model
module tb_mtsp_gscs_bank;
    localparam int CC = 4;

    logic               clk;
    logic               rst_n;
    logic [CC-1:0]      req_nen;
    logic [16*CC-1:0]   req_op;
    logic [64*CC-1:0]   req_data;
    logic [64*CC-1:0]   gscs_data;
    logic               host_nwe;
    logic [63:0]        host_data;
    logic [63:0]        counters;
    logic [3:0]         ovf;

    int          checks = 0;
    int          errors = 0;
    int          cnt [4];
    bit          ovf_m [4];
    logic [63:0] gexp [CC];

    mtsp_gscs_bank #(.CORE_COUNT(CC)) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .REQ_nEN   (req_nen),
        .REQ_OP    (req_op),
        .REQ_DATA  (req_data),
        .GSCs_DATA (gscs_data),
        .HOST_nWE  (host_nwe),
        .HOST_DATA (host_data),
        .COUNTERS  (counters),
        .OVF       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        req_nen   = '1;
        req_op    = '0;
        req_data  = '0;
        host_nwe  = 1'b1;
        host_data = '0;
    endtask

    task automatic set_req(input int c, input int l, input logic [3:0] op, input logic [15:0] d);
        req_nen[c] = 1'b0;
        req_op[16*c + 4*(3-l) +: 4]    = op;
        req_data[64*c + 16*(3-l) +: 16] = d;
    endtask

    function automatic logic [15:0] gret(input int c, input int l);
        logic [63:0] w;
        w = gscs_data[64*c +: 64];
        return w[16*(3-l) +: 16];
    endfunction

    function automatic logic [15:0] cval(input int l);
        return counters[16*(3-l) +: 16];
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            cnt[l]   = 0;
            ovf_m[l] = 1'b0;
        end
        for (int c = 0; c < CC; c++) gexp[c] = '0;
    endtask

    // Lanes evaluated in core order using plain integer arithmetic.
    task automatic model_edge();
        int v, d, newv [4];
        bit oset [4];
        logic [3:0] op;
        for (int l = 0; l < 4; l++) begin
            v = cnt[l];
            oset[l] = 1'b0;
            for (int c = 0; c < CC; c++) begin
                if (!req_nen[c]) begin
                    op = req_op[16*c + 4*(3-l) +: 4];
                    d  = int'(req_data[64*c + 16*(3-l) +: 16]);
                    gexp[c][16*(3-l) +: 16] = v[15:0];
                    if (op[3]) begin
                        case (op[2:0])
                            3'd1: begin v = v + d; if (v > 65535) begin oset[l] = 1'b1; v = v - 65536; end end
                            3'd2: begin if (d > v) begin oset[l] = 1'b1; v = v + 65536; end v = v - d; end
                            3'd3, 3'd6: v = d;
                            3'd4: if (d < v) v = d;
                            3'd5: if (d > v) v = d;
                            3'd7: v = 0;
                            default: ;
                        endcase
                    end
                end
            end
            newv[l] = v;
        end
        for (int l = 0; l < 4; l++) begin
            if (!host_nwe) begin
                cnt[l]   = int'(host_data[16*(3-l) +: 16]);
                ovf_m[l] = 1'b0;
            end else begin
                cnt[l]   = newv[l];
                ovf_m[l] = ovf_m[l] | oset[l];
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] ec;
        logic [3:0]  eo;
        for (int l = 0; l < 4; l++) begin
            ec[16*(3-l) +: 16] = cnt[l][15:0];
            eo[3-l] = ovf_m[l];
        end
        chk({tag, "_counters"}, counters, ec);
        chk({tag, "_ovf"}, {60'd0, ovf}, {60'd0, eo});
        for (int c = 0; c < CC; c++) chk($sformatf("%s_gscs%0d", tag, c), gscs_data[64*c +: 64], gexp[c]);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [15:0] rnd_data();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'hFFFE;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        clear_reqs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            clear_reqs();
            set_req(0, 0, 4'b1001, 16'd5);
            step("add5");
            chk($sformatf("add5_ret%0d", k), {48'd0, gret(0, 0)}, 64'(5 * k));
        end
        chk("add5_x15", {48'd0, cval(0)}, 64'd15);

        clear_reqs();
        host_nwe  = 1'b0;
        host_data = {16'd15, 16'd10, 16'hFFFE, 16'd50};
        step("load1");

        clear_reqs();
        set_req(0, 1, 4'b1001, 16'd3);
        set_req(1, 1, 4'b1001, 16'd4);
        set_req(2, 2, 4'b1001, 16'd3);
        step("chain");
        chk("chain_c0y", {48'd0, gret(0, 1)}, 64'd10);
        chk("chain_c1y", {48'd0, gret(1, 1)}, 64'd13);
        chk("chain_y17", {48'd0, cval(1)}, 64'd17);
        chk("chain_c2z", {48'd0, gret(2, 2)}, 64'hFFFE);
        chk("chain_z1", {48'd0, cval(2)}, 64'd1);
        chk("chain_ovfz", {63'd0, ovf[1]}, 64'd1);

        clear_reqs();
        set_req(0, 2, 4'b1010, 16'd1);
        step("sticky");
        chk("sticky_ovfz", {63'd0, ovf[1]}, 64'd1);

        clear_reqs();
        set_req(0, 3, 4'b1100, 16'd20);
        set_req(1, 3, 4'b1101, 16'd30);
        set_req(3, 3, 4'b1111, 16'd0);
        step("minmax");
        chk("minmax_c0", {48'd0, gret(0, 3)}, 64'd50);
        chk("minmax_c1", {48'd0, gret(1, 3)}, 64'd20);
        chk("minmax_c3", {48'd0, gret(3, 3)}, 64'd30);
        chk("minmax_w0", {48'd0, cval(3)}, 64'd0);
        chk("minmax_c2hold", {48'd0, gret(2, 2)}, 64'hFFFE);

        clear_reqs();
        host_nwe  = 1'b0;
        host_data = {16'd0, 16'd0, 16'h0100, 16'h0040};
        set_req(0, 3, 4'b1110, 16'h1234);
        step("hostx");
        chk("hostx_ret", {48'd0, gret(0, 3)}, 64'd0);
        chk("hostx_w", {48'd0, cval(3)}, 64'h0040);
        chk("hostx_ovf", {60'd0, ovf}, 64'd0);

        clear_reqs();
        set_req(0, 0, 4'b1001, 16'd0);
        set_req(1, 0, 4'b1010, 16'd0);
        step("zero_ops");
        chk("zero_ops_ovf", {60'd0, ovf}, 64'd0);

        clear_reqs();
        set_req(0, 0, 4'b1010, 16'd1);
        step("borrow");
        chk("borrow_x", {48'd0, cval(0)}, 64'hFFFF);
        chk("borrow_ovfx", {63'd0, ovf[3]}, 64'd1);

        clear_reqs();
        host_nwe  = 1'b0;
        host_data = {16'hFFFF, 16'd0, 16'd0, 16'd0};
        step("load2");
        clear_reqs();
        set_req(0, 0, 4'b1001, 16'd1);
        step("carry");
        chk("carry_x", {48'd0, cval(0)}, 64'd0);
        chk("carry_ovfx", {63'd0, ovf[3]}, 64'd1);

        for (int k = 0; k < 300; k++) begin
            clear_reqs();
            for (int c = 0; c < CC; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int l = 0; l < 4; l++) set_req(c, l, 4'($urandom), rnd_data());
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                host_nwe  = 1'b0;
                host_data = {rnd_data(), rnd_data(), rnd_data(), rnd_data()};
            end
            step("rand");
        end

        clear_reqs();
        set_req(0, 0, 4'b1011, 16'h5555);
        set_req(1, 1, 4'b1001, 16'h0003);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        #2;
        rst_n = 1'b1;
        clear_reqs();
        set_req(0, 0, 4'b1000, 16'd0);
        step("post_rst");
        chk("post_rst_ret", {48'd0, gret(0, 0)}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
